// File: rtl/branch_resolve_unit_if.sv
// Branch request channel between decode and the branch resolve unit.
// master: requester drives request fields + valid; slave: returns ready.
interface branch_resolve_unit_if;
  logic        br_valid;
  logic        br_ready;
  logic        br_is_reg;
  logic [2:0]  br_cond;
  logic [8:0]  br_imm;
  logic [15:0] br_reg_val;
  logic [15:0] pc_plus2;

  modport master (
    output br_valid,
    output br_is_reg,
    output br_cond,
    output br_imm,
    output br_reg_val,
    output pc_plus2,
    input  br_ready
  );

  modport slave (
    input  br_valid,
    input  br_is_reg,
    input  br_cond,
    input  br_imm,
    input  br_reg_val,
    input  pc_plus2,
    output br_ready
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve: evaluates N/Z/V conditions, drives PC redirect + flush.
// Ports: clk, rst (async low), br (slave), flags in; stall/redirect/target/flush/taken_cnt out.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  br,
  input  logic                  flag_n,
  input  logic                  flag_z,
  input  logic                  flag_v,
  input  logic                  flag_wr_pending,
  output logic                  stall,
  output logic                  pc_redirect,
  output logic [15:0]           pc_target,
  output logic                  flush,
  output logic [15:0]           taken_cnt
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAG,
    FLUSH
  } state_e;

  typedef struct packed {
    logic        is_reg;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [15:0] reg_val;
    logic [15:0] pc;
  } req_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        pc_redirect_q, pc_redirect_d;
  logic [15:0] pc_target_q, pc_target_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  req_t        cur;
  logic        cond_ok;
  logic        resolve;
  logic [15:0] tgt;

  // WAIT_FLAG resolves the latched copy; IDLE resolves the live request.
  always_comb begin
    cur = '{
      is_reg:  br.br_is_reg,
      cond:    br.br_cond,
      imm:     br.br_imm,
      reg_val: br.br_reg_val,
      pc:      br.pc_plus2
    };
    if (state_q == WAIT_FLAG) cur = req_q;
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (cur.cond)
      3'b000: cond_ok = ~flag_z;
      3'b001: cond_ok = flag_z;
      3'b010: cond_ok = ~flag_z & ~flag_n;
      3'b011: cond_ok = flag_n;
      3'b100: cond_ok = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_ok = flag_n | flag_z;
      3'b110: cond_ok = flag_v;
      3'b111: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Word offset: sign-extend imm and shift left one.
  always_comb begin
    tgt = cur.pc + {{6{cur.imm[8]}}, cur.imm, 1'b0};
    if (cur.is_reg) tgt = cur.reg_val;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    pc_redirect_d = 1'b0;
    pc_target_d   = pc_target_q;
    taken_cnt_d   = taken_cnt_q;
    resolve       = 1'b0;
    stall         = 1'b0;
    br.br_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        br.br_ready = 1'b1;
        if (br.br_valid) begin
          if (flag_wr_pending) begin
            req_d   = cur;
            state_d = WAIT_FLAG;
            stall   = 1'b1;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      WAIT_FLAG: begin
        stall   = 1'b1;
        resolve = 1'b1;
        state_d = IDLE;
      end
      FLUSH: begin
        stall = 1'b1;
        if (cnt_q == 3'd1) state_d = IDLE;
        else cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (resolve && cond_ok) begin
      pc_redirect_d = 1'b1;
      pc_target_d   = tgt;
      state_d       = FLUSH;
      cnt_d         = FC;
      if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign flush       = (state_q == FLUSH);
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit.
// One task per scenario, inline checks, single summary line.
module tb_branch_resolve_unit;
  logic        clk;
  logic        rst;
  logic        flag_n, flag_z, flag_v, flag_wr_pending;
  logic        stall, pc_redirect, flush;
  logic [15:0] pc_target, taken_cnt;
  int          checks;
  int          errors;

  branch_resolve_unit_if bif ();

  branch_resolve_unit #(.FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .br              (bif),
    .flag_n          (flag_n),
    .flag_z          (flag_z),
    .flag_v          (flag_v),
    .flag_wr_pending (flag_wr_pending),
    .stall           (stall),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .flush           (flush),
    .taken_cnt       (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic is_reg, input logic [2:0] c,
                     input logic [8:0] imm, input logic [15:0] rv,
                     input logic [15:0] pc);
    bif.br_valid   = 1'b1;
    bif.br_is_reg  = is_reg;
    bif.br_cond    = c;
    bif.br_imm     = imm;
    bif.br_reg_val = rv;
    bif.pc_plus2   = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.br_valid = 1'b0;
    bif.br_is_reg = 1'b0;
    bif.br_cond = 3'd0;
    bif.br_imm = 9'd0;
    bif.br_reg_val = 16'd0;
    bif.pc_plus2 = 16'd0;
    flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0;
    flag_wr_pending = 1'b0;
    repeat (2) tick();
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bif.br_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", pc_redirect); end
    checks++; if (pc_target !== 16'h0000) begin errors++; $display("FAIL reset_target got %h exp 0000", pc_target); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (taken_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", taken_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_taken_b();
    flag_z = 1'b1;
    req(1'b0, 3'b001, 9'h004, 16'h0000, 16'h0010);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tb_stall0 got %b exp 0", stall); end
    tick();
    bif.br_valid = 1'b0;
    checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL tb_redir got %b exp 1", pc_redirect); end
    checks++; if (pc_target !== 16'h0018) begin errors++; $display("FAIL tb_target got %h exp 0018", pc_target); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tb_flush1 got %b exp 1", flush); end
    checks++; if (bif.br_ready !== 1'b0) begin errors++; $display("FAIL tb_ready1 got %b exp 0", bif.br_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tb_stall1 got %b exp 1", stall); end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL tb_cnt got %0d exp 1", taken_cnt); end
    tick();
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL tb_redir2 got %b exp 0", pc_redirect); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tb_flush2 got %b exp 1", flush); end
    checks++; if (bif.br_ready !== 1'b0) begin errors++; $display("FAIL tb_ready2 got %b exp 0", bif.br_ready); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL tb_flush3 got %b exp 0", flush); end
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL tb_ready3 got %b exp 1", bif.br_ready); end
  endtask

  task automatic test_not_taken();
    flag_z = 1'b1;
    req(1'b0, 3'b000, 9'h020, 16'h0000, 16'h0400);
    tick();
    bif.br_valid = 1'b0;
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL nt_redir got %b exp 0", pc_redirect); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush got %b exp 0", flush); end
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL nt_ready got %b exp 1", bif.br_ready); end
    checks++; if (pc_target !== 16'h0018) begin errors++; $display("FAIL nt_target got %h exp 0018", pc_target); end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL nt_cnt got %0d exp 1", taken_cnt); end
    tick();
  endtask

  task automatic test_targets();
    req(1'b0, 3'b111, 9'h1FF, 16'h0000, 16'h0000);
    tick();
    bif.br_valid = 1'b0;
    checks++; if (pc_target !== 16'hFFFE) begin errors++; $display("FAIL wrap_target got %h exp fffe", pc_target); end
    checks++; if (taken_cnt !== 16'd2) begin errors++; $display("FAIL wrap_cnt got %0d exp 2", taken_cnt); end
    repeat (2) tick();
    req(1'b1, 3'b111, 9'h004, 16'hBEEF, 16'h1234);
    tick();
    bif.br_valid = 1'b0;
    checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL br_redir got %b exp 1", pc_redirect); end
    checks++; if (pc_target !== 16'hBEEF) begin errors++; $display("FAIL br_target got %h exp beef", pc_target); end
    checks++; if (taken_cnt !== 16'd3) begin errors++; $display("FAIL br_cnt got %0d exp 3", taken_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_interlock();
    flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0;
    flag_wr_pending = 1'b1;
    req(1'b0, 3'b011, 9'h010, 16'h0000, 16'h0100);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL il_stall0 got %b exp 1", stall); end
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL il_ready0 got %b exp 1", bif.br_ready); end
    tick();
    // ALU has now written N=1; perturb live inputs to prove latching
    flag_n = 1'b1;
    flag_wr_pending = 1'b1;
    req(1'b0, 3'b000, 9'h0AA, 16'h0000, 16'h7000);
    bif.br_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL il_stall1 got %b exp 1", stall); end
    checks++; if (bif.br_ready !== 1'b0) begin errors++; $display("FAIL il_ready1 got %b exp 0", bif.br_ready); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL il_redir1 got %b exp 0", pc_redirect); end
    tick();
    flag_wr_pending = 1'b0;
    checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL il_redir2 got %b exp 1", pc_redirect); end
    checks++; if (pc_target !== 16'h0120) begin errors++; $display("FAIL il_target got %h exp 0120", pc_target); end
    checks++; if (taken_cnt !== 16'd4) begin errors++; $display("FAIL il_cnt got %0d exp 4", taken_cnt); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL il_flush got %b exp 1", flush); end
    repeat (2) tick();
    flag_n = 1'b0;
  endtask

  task automatic test_back_to_back();
    req(1'b0, 3'b111, 9'h001, 16'h0000, 16'h0200);
    tick();
    checks++; if (pc_target !== 16'h0202) begin errors++; $display("FAIL b2b_t1 got %h exp 0202", pc_target); end
    req(1'b0, 3'b111, 9'h002, 16'h0000, 16'h0200);
    tick();
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL b2b_hold got %b exp 0", pc_redirect); end
    checks++; if (pc_target !== 16'h0202) begin errors++; $display("FAIL b2b_t2 got %h exp 0202", pc_target); end
    tick();
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bif.br_ready); end
    tick();
    bif.br_valid = 1'b0;
    checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL b2b_redir got %b exp 1", pc_redirect); end
    checks++; if (pc_target !== 16'h0204) begin errors++; $display("FAIL b2b_t3 got %h exp 0204", pc_target); end
    checks++; if (taken_cnt !== 16'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", taken_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_sweep();
    logic [7:0]  masks [8];
    logic [5:0]  idx;
    logic [15:0] exp_t;
    logic [15:0] last_t;
    logic        exp_k;
    masks[0] = 8'h33; masks[1] = 8'hCC; masks[2] = 8'h03; masks[3] = 8'hF0;
    masks[4] = 8'hCF; masks[5] = 8'hFC; masks[6] = 8'hAA; masks[7] = 8'hFF;
    force dut.taken_cnt_q = 16'hFFFF;
    tick();
    release dut.taken_cnt_q;
    checks++; if (taken_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preset got %h exp ffff", taken_cnt); end
    last_t = 16'h0204;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        idx = 6'(c * 8 + f);
        {flag_n, flag_z, flag_v} = 3'(f);
        req(1'b0, 3'(c), {3'b000, idx}, 16'h0000, 16'h1000);
        exp_t = 16'h1000 + {9'd0, idx, 1'b0};
        exp_k = masks[c][f];
        tick();
        bif.br_valid = 1'b0;
        if (exp_k) last_t = exp_t;
        checks++; if (pc_redirect !== exp_k) begin errors++; $display("FAIL sweep_redir c=%0d nzv=%0d got %b exp %b", c, f, pc_redirect, exp_k); end
        checks++; if (pc_target !== last_t) begin errors++; $display("FAIL sweep_target c=%0d nzv=%0d got %h exp %h", c, f, pc_target, last_t); end
        if (exp_k) repeat (2) tick();
      end
    end
    checks++; if (taken_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", taken_cnt); end
    {flag_n, flag_z, flag_v} = 3'b000;
  endtask

  task automatic test_reset_mid();
    req(1'b0, 3'b111, 9'h008, 16'h0000, 16'h0300);
    tick();
    bif.br_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", flush); end
    #1 rst = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rm_flush got %b exp 0", flush); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rm_redir got %b exp 0", pc_redirect); end
    checks++; if (taken_cnt !== 16'h0000) begin errors++; $display("FAIL rm_cnt got %h exp 0000", taken_cnt); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bif.br_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bif.br_ready); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rm_redir2 got %b exp 0", pc_redirect); end
    // reset while waiting on flags: the latched request must vanish
    flag_wr_pending = 1'b1;
    req(1'b0, 3'b111, 9'h008, 16'h0000, 16'h0300);
    tick();
    bif.br_valid = 1'b0;
    flag_wr_pending = 1'b0;
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL rw_redir got %b exp 0", pc_redirect); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_stall got %b exp 0", stall); end
    checks++; if (pc_target !== 16'h0000) begin errors++; $display("FAIL rw_target got %h exp 0000", pc_target); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_taken_b();
    test_not_taken();
    test_targets();
    test_interlock();
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
